// File: rtl/mitm_bus_pkg.sv
// rtl/mitm_bus_pkg.sv - shared state encoding and defaults for the MITM bus controller
//
// Contents:
//   bus_state_t          FSM encoding: IDLE, READY, SHIFT, PASS
//   DEF_BUF_SIZE         default chunk buffer width, also used by the MITM logic
//   DEF_TIMEOUT_CYCLES   default chunk abort timeout
//   chunk_size_width()   width of a chunk-length field able to hold 0..buf_size
package mitm_bus_pkg;

    localparam int DEF_BUF_SIZE       = 9;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_SHIFT,
        ST_PASS
    } bus_state_t;

    function automatic int chunk_size_width(input int buf_size);
        return $clog2(buf_size + 1);
    endfunction

endpackage

// File: rtl/bus_sync_edge.sv
// rtl/bus_sync_edge.sv - two-flop synchronizer with rise/fall pulses
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   din          asynchronous pin
//   sync         synchronized level (two flops after din)
//   rise, fall   one-cycle pulses on edges of sync
module bus_sync_edge
    import mitm_bus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/mitm_bus_ctrl.sv
// rtl/mitm_bus_ctrl.sv - bus-side chunk capture / fake-bit injection for a Microwire/SPI link
//
// Optional feature macro: CHUNK_TIMEOUT_EN (abort a stalled chunk after TIMEOUT_CYCLES).
//
// Ports:
//   sys_clk, rst_n                     clock, asynchronous active-low reset
//   m_sclk, m_cs, m_mosi               pins from the real master (CS active-high)
//   s_miso                             pin from the real slave
//   s_sclk, s_cs, s_mosi               pins to the slave
//   m_miso                             pin to the master
//   comm_active                        transaction in progress (synchronized CS)
//   bus_ready                          idle, a command is accepted in READY
//   cmd_next_chunk, cmd_finish         one-cycle command pulses
//   next_chunk_size                    chunk length in bits (clamped to BUF_SIZE)
//   fake_miso_select/fake_mosi_select  substitute that direction during the chunk
//   fake_miso_data/fake_mosi_data      right-aligned fake bits, MSB first
//   real_miso_data/real_mosi_data      captured bits, right-aligned
module mitm_bus_ctrl
    import mitm_bus_pkg::*;
#(
    parameter int BUF_SIZE       = DEF_BUF_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int CSW           = chunk_size_width(BUF_SIZE)
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                m_sclk,
    input  logic                m_cs,
    input  logic                m_mosi,
    input  logic                s_miso,
    output logic                s_sclk,
    output logic                s_cs,
    output logic                s_mosi,
    output logic                m_miso,
    output logic                comm_active,
    output logic                bus_ready,
    input  logic                cmd_next_chunk,
    input  logic                cmd_finish,
    input  logic [CSW-1:0]      next_chunk_size,
    input  logic                fake_miso_select,
    input  logic                fake_mosi_select,
    input  logic [BUF_SIZE-1:0] fake_miso_data,
    input  logic [BUF_SIZE-1:0] fake_mosi_data,
    output logic [BUF_SIZE-1:0] real_miso_data,
    output logic [BUF_SIZE-1:0] real_mosi_data
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic miso_sync, miso_rise, miso_fall;

    bus_sync_edge u_sync_sclk (.clk(sys_clk), .rst_n(rst_n), .din(m_sclk),
                               .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall));
    bus_sync_edge u_sync_cs   (.clk(sys_clk), .rst_n(rst_n), .din(m_cs),
                               .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));
    bus_sync_edge u_sync_mosi (.clk(sys_clk), .rst_n(rst_n), .din(m_mosi),
                               .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));
    bus_sync_edge u_sync_miso (.clk(sys_clk), .rst_n(rst_n), .din(s_miso),
                               .sync(miso_sync), .rise(miso_rise), .fall(miso_fall));

    // Only the synchronized levels and the SCLK rise drive the datapath.
    logic unused_edges;
    assign unused_edges = ^{sclk_fall, cs_rise, cs_fall, mosi_rise, mosi_fall, miso_rise, miso_fall};

    bus_state_t          state, state_nxt;
    logic [CSW-1:0]      size_q, size_nxt, size_clamped;
    logic [CSW-1:0]      cnt_q, cnt_nxt, bit_idx;
    logic                mosi_sel_q, mosi_sel_nxt, miso_sel_q, miso_sel_nxt;
    logic [BUF_SIZE-1:0] fake_mosi_q, fake_mosi_nxt, fake_miso_q, fake_miso_nxt;
    logic [BUF_SIZE-1:0] real_mosi_q, real_mosi_nxt, real_miso_q, real_miso_nxt;
    logic                s_mosi_nxt, m_miso_nxt;
    logic                timeout_hit;

`ifdef CHUNK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // Cycles since the last SCLK rise (or since entering SHIFT).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state != ST_SHIFT || sclk_rise) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        size_nxt      = size_q;
        cnt_nxt       = cnt_q;
        mosi_sel_nxt  = mosi_sel_q;
        miso_sel_nxt  = miso_sel_q;
        fake_mosi_nxt = fake_mosi_q;
        fake_miso_nxt = fake_miso_q;
        real_mosi_nxt = real_mosi_q;
        real_miso_nxt = real_miso_q;
        size_clamped  = (next_chunk_size > CSW'(BUF_SIZE)) ? CSW'(BUF_SIZE) : next_chunk_size;

        unique case (state)
            ST_IDLE: begin
                if (cs_sync) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (cmd_finish) begin
                    state_nxt = ST_PASS;
                end else if (cmd_next_chunk) begin
                    size_nxt      = size_clamped;
                    cnt_nxt       = '0;
                    mosi_sel_nxt  = fake_mosi_select;
                    miso_sel_nxt  = fake_miso_select;
                    fake_mosi_nxt = fake_mosi_data;
                    fake_miso_nxt = fake_miso_data;
                    real_mosi_nxt = '0;
                    real_miso_nxt = '0;
                    if (size_clamped != '0) state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    real_mosi_nxt = {real_mosi_q[BUF_SIZE-2:0], mosi_sync};
                    real_miso_nxt = {real_miso_q[BUF_SIZE-2:0], miso_sync};
                    cnt_nxt       = cnt_q + CSW'(1);
                    if (cnt_q + CSW'(1) == size_q) state_nxt = ST_READY;
                end else if (timeout_hit) begin
                    state_nxt = ST_READY;
                end
            end
            ST_PASS: begin
            end
            default: state_nxt = ST_IDLE;
        endcase

        // CS drop ends the transaction from any state; captured bits are kept.
        if (!cs_sync && state != ST_IDLE) begin
            state_nxt    = ST_IDLE;
            mosi_sel_nxt = 1'b0;
            miso_sel_nxt = 1'b0;
        end

        // Output bits are chosen from next-state values so the first fake bit
        // appears right after the command and each following one right after a rise.
        bit_idx    = size_nxt - CSW'(1) - cnt_nxt;
        s_mosi_nxt = (state_nxt == ST_SHIFT && mosi_sel_nxt) ? fake_mosi_nxt[bit_idx] : mosi_sync;
        m_miso_nxt = (state_nxt == ST_SHIFT && miso_sel_nxt) ? fake_miso_nxt[bit_idx] : miso_sync;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            size_q      <= '0;
            cnt_q       <= '0;
            mosi_sel_q  <= 1'b0;
            miso_sel_q  <= 1'b0;
            fake_mosi_q <= '0;
            fake_miso_q <= '0;
            real_mosi_q <= '0;
            real_miso_q <= '0;
            s_sclk      <= 1'b0;
            s_cs        <= 1'b0;
            s_mosi      <= 1'b0;
            m_miso      <= 1'b0;
        end else begin
            state       <= state_nxt;
            size_q      <= size_nxt;
            cnt_q       <= cnt_nxt;
            mosi_sel_q  <= mosi_sel_nxt;
            miso_sel_q  <= miso_sel_nxt;
            fake_mosi_q <= fake_mosi_nxt;
            fake_miso_q <= fake_miso_nxt;
            real_mosi_q <= real_mosi_nxt;
            real_miso_q <= real_miso_nxt;
            // One register stage after the synchronizer gives every pin the same latency.
            s_sclk      <= sclk_sync;
            s_cs        <= cs_sync;
            s_mosi      <= s_mosi_nxt;
            m_miso      <= m_miso_nxt;
        end
    end

    assign comm_active    = (state != ST_IDLE);
    assign bus_ready      = (state == ST_IDLE) || (state == ST_READY);
    assign real_mosi_data = real_mosi_q;
    assign real_miso_data = real_miso_q;

endmodule

// File: tb/tb_mitm_bus_ctrl.sv
// tb/tb_mitm_bus_ctrl.sv - self-checking bench for mitm_bus_ctrl
module tb_mitm_bus_ctrl;

    localparam int BUF  = 9;
    localparam int TOUT = 16;
    localparam int CSW  = 4;

    localparam int M_OFF  = 0;
    localparam int M_RDY  = 1;
    localparam int M_CHK  = 2;
    localparam int M_PASS = 3;

    logic           sys_clk = 1'b0;
    logic           rst_n   = 1'b1;
    logic           m_sclk = 1'b0, m_cs = 1'b0, m_mosi = 1'b0, s_miso = 1'b0;
    logic           s_sclk, s_cs, s_mosi, m_miso, comm_active, bus_ready;
    logic           cmd_next_chunk = 1'b0, cmd_finish = 1'b0;
    logic [CSW-1:0] next_chunk_size = '0;
    logic           fake_miso_select = 1'b0, fake_mosi_select = 1'b0;
    logic [BUF-1:0] fake_miso_data = '0, fake_mosi_data = '0;
    logic [BUF-1:0] real_miso_data, real_mosi_data;

    int checks = 0;
    int errors = 0;

    mitm_bus_ctrl #(.BUF_SIZE(BUF), .TIMEOUT_CYCLES(TOUT)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m_sclk(m_sclk), .m_cs(m_cs), .m_mosi(m_mosi), .s_miso(s_miso),
        .s_sclk(s_sclk), .s_cs(s_cs), .s_mosi(s_mosi), .m_miso(m_miso),
        .comm_active(comm_active), .bus_ready(bus_ready),
        .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish),
        .next_chunk_size(next_chunk_size),
        .fake_miso_select(fake_miso_select), .fake_mosi_select(fake_mosi_select),
        .fake_miso_data(fake_miso_data), .fake_mosi_data(fake_mosi_data),
        .real_miso_data(real_miso_data), .real_mosi_data(real_mosi_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Transaction-level reference: pin histories plus the current chunk.
    int mode, sz, got, cap_mosi, cap_miso, fk_mosi, fk_miso, idle;
    bit sel_mosi, sel_miso;
    bit h_sclk[$], h_cs[$], h_mosi[$], h_miso[$];
    bit p_next, p_fin, p_smo, p_smi;
    int p_size, p_fmo, p_fmi;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode = M_OFF; sz = 0; got = 0; cap_mosi = 0; cap_miso = 0;
        fk_mosi = 0; fk_miso = 0; idle = 0; sel_mosi = 0; sel_miso = 0;
        h_sclk.delete(); h_cs.delete(); h_mosi.delete(); h_miso.delete();
        for (int i = 0; i < 4; i++) begin
            h_sclk.push_back(1'b0); h_cs.push_back(1'b0);
            h_mosi.push_back(1'b0); h_miso.push_back(1'b0);
        end
    endtask

    // The controller acts at edge n on what the pins were at edge n-2.
    task automatic model_edge();
        int k;
        bit cs_seen, rise, d_mosi, d_miso;
        k       = h_cs.size();
        cs_seen = h_cs[k-3];
        rise    = h_sclk[k-3] && !h_sclk[k-4];
        d_mosi  = h_mosi[k-3];
        d_miso  = h_miso[k-3];
        if (mode == M_OFF) begin
            if (cs_seen) mode = M_RDY;
        end else if (!cs_seen) begin
            mode = M_OFF;
        end else if (mode == M_RDY) begin
            if (p_fin) begin
                mode = M_PASS;
            end else if (p_next) begin
                sz = (p_size > BUF) ? BUF : p_size;
                got = 0; cap_mosi = 0; cap_miso = 0; idle = 0;
                sel_mosi = p_smo; sel_miso = p_smi; fk_mosi = p_fmo; fk_miso = p_fmi;
                if (sz != 0) mode = M_CHK;
            end
        end else if (mode == M_CHK) begin
            if (rise) begin
                cap_mosi = cap_mosi * 2 + int'(d_mosi);
                cap_miso = cap_miso * 2 + int'(d_miso);
                got++;
                idle = 0;
                if (got == sz) mode = M_RDY;
            end
`ifdef CHUNK_TIMEOUT_EN
            else begin
                idle++;
                if (idle == TOUT) mode = M_RDY;
            end
`endif
        end
    endtask

    task automatic compare();
        int k, e_smosi, e_mmiso;
        k = h_cs.size();
        e_smosi = int'(h_mosi[k-3]);
        e_mmiso = int'(h_miso[k-3]);
        if (mode == M_CHK && sel_mosi) e_smosi = (fk_mosi >> (sz - 1 - got)) & 1;
        if (mode == M_CHK && sel_miso) e_mmiso = (fk_miso >> (sz - 1 - got)) & 1;
        chk("s_sclk", int'(s_sclk), int'(h_sclk[k-3]));
        chk("s_cs", int'(s_cs), int'(h_cs[k-3]));
        chk("s_mosi", int'(s_mosi), e_smosi);
        chk("m_miso", int'(m_miso), e_mmiso);
        chk("comm_active", int'(comm_active), int'(mode != M_OFF));
        chk("bus_ready", int'(bus_ready), int'(mode == M_OFF || mode == M_RDY));
        if (mode == M_OFF || mode == M_RDY) begin
            chk("real_mosi_data", int'(real_mosi_data), cap_mosi);
            chk("real_miso_data", int'(real_miso_data), cap_miso);
        end
    endtask

    task automatic tick();
        h_sclk.push_back(m_sclk); h_cs.push_back(m_cs);
        h_mosi.push_back(m_mosi); h_miso.push_back(s_miso);
        p_next = cmd_next_chunk; p_fin = cmd_finish; p_size = int'(next_chunk_size);
        p_smo = fake_mosi_select; p_smi = fake_miso_select;
        p_fmo = int'(fake_mosi_data); p_fmi = int'(fake_miso_data);
        @(posedge sys_clk);
        #1;
        while (h_cs.size() > 8) begin
            void'(h_sclk.pop_front()); void'(h_cs.pop_front());
            void'(h_mosi.pop_front()); void'(h_miso.pop_front());
        end
        model_edge();
        compare();
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!(bus_ready && comm_active) && n < 30) begin
            tick();
            n++;
        end
        chk(nm, int'(bus_ready && comm_active), 1);
    endtask

    task automatic issue_chunk(input int size, input bit smo, input bit smi, input int fmo, input int fmi);
        next_chunk_size  = CSW'(size);
        fake_mosi_select = smo;
        fake_miso_select = smi;
        fake_mosi_data   = BUF'(fmo);
        fake_miso_data   = BUF'(fmi);
        cmd_next_chunk   = 1'b1;
        tick();
        cmd_next_chunk   = 1'b0;
    endtask

    // Master shifts n bits MSB first; returns what it saw on m_miso at each of its rises.
    task automatic spi_bits(input int n, input int mo, output int seen);
        int hp;
        seen = 0;
        for (int i = n - 1; i >= 0; i--) begin
            hp     = int'($urandom_range(2, 4));
            m_sclk = 1'b0;
            m_mosi = 1'((mo >> i) & 1);
            s_miso = 1'($urandom_range(0, 1));
            repeat (hp) tick();
            m_sclk = 1'b1;
            seen   = seen * 2 + int'(m_miso);
            repeat (hp) tick();
        end
        m_sclk = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int seen, nch, size, nb, cut;
        bit dropped;

        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_bus_ready", int'(bus_ready), 1);
        chk("reset_comm_active", int'(comm_active), 0);
        chk("reset_pins", int'({s_cs, s_sclk, s_mosi, m_miso}), 0);
        chk("reset_real", int'({real_mosi_data, real_miso_data}), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Size 3, mosi 1,1,0.
        m_cs = 1'b1;
        wait_ready("t2_wait_ready");
        issue_chunk(3, 1'b0, 1'b0, 0, 0);
        for (int i = 2; i >= 0; i--) begin
            m_sclk = 1'b0;
            m_mosi = 1'((6 >> i) & 1);
            repeat (3) tick();
            m_sclk = 1'b1;
            tick();
            tick();
            if (i == 0) chk("t2_ready_before", int'(bus_ready), 0);
            tick();
            if (i == 0) chk("t2_ready_after", int'(bus_ready), 1);
        end
        m_sclk = 1'b0;
        tick();
        chk("t2_real_mosi", int'(real_mosi_data), 'h006);

        // Size 9 with fake MISO.
        issue_chunk(9, 1'b0, 1'b1, 0, 'h0ff);
        spi_bits(9, 'h14a, seen);
        wait_ready("t3_wait_ready");
        chk("t3_m_miso_seq", seen, 'h0ff);
        chk("t3_real_mosi", int'(real_mosi_data), 'h14a);

        // Finish then 8 bits of pass-through.
        cmd_finish = 1'b1;
        tick();
        cmd_finish = 1'b0;
        spi_bits(8, 'haa, seen);
        chk("t4_pass_busy", int'(bus_ready), 0);
        m_cs = 1'b0;
        repeat (4) tick();
        chk("t4_idle_ready", int'(bus_ready), 1);
        chk("t4_idle_inactive", int'(comm_active), 0);

        // CS drops after 4 of 9 bits.
        m_cs = 1'b1;
        wait_ready("t5_wait_ready");
        issue_chunk(9, 1'b0, 1'b0, 0, 0);
        spi_bits(4, 'hb, seen);
        m_cs = 1'b0;
        repeat (4) tick();
        chk("t5_real_mosi", int'(real_mosi_data), 'h00b);
        chk("t5_comm_active", int'(comm_active), 0);
        issue_chunk(3, 1'b0, 1'b0, 0, 0);
        tick();
        chk("t5_ignored_ready", int'(bus_ready), 1);
        chk("t5_ignored_real", int'(real_mosi_data), 'h00b);

`ifdef CHUNK_TIMEOUT_EN
        m_cs = 1'b1;
        wait_ready("t6_wait_ready");
        issue_chunk(5, 1'b0, 1'b0, 0, 0);
        spi_bits(2, 'h2, seen);
        wait_ready("t6_timeout_ready");
        m_cs = 1'b0;
        repeat (4) tick();
`endif

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            m_cs = 1'b1;
            dropped = 1'b0;
            wait_ready("rnd_wait_ready");
            nch = int'($urandom_range(1, 4));
            for (int c = 0; c < nch && !dropped; c++) begin
                size = int'($urandom_range(0, 12));
                issue_chunk(size, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
                nb  = (size > BUF) ? BUF : size;
                cut = int'($urandom_range(0, 7));
                if (cut == 0 && nb > 1) begin
                    spi_bits(int'($urandom_range(1, nb - 1)), int'($urandom_range(0, 511)), seen);
                    m_cs = 1'b0;
                    dropped = 1'b1;
                end else begin
                    spi_bits(nb, int'($urandom_range(0, 511)), seen);
                    wait_ready("rnd_chunk_done");
                end
            end
            if (!dropped && $urandom_range(0, 1) == 1) begin
                cmd_finish     = 1'b1;
                cmd_next_chunk = 1'($urandom_range(0, 1));
                tick();
                cmd_finish     = 1'b0;
                cmd_next_chunk = 1'b0;
                spi_bits(int'($urandom_range(1, 8)), int'($urandom_range(0, 255)), seen);
                cmd_next_chunk = 1'b1;
                tick();
                cmd_next_chunk = 1'b0;
                chk("rnd_pass_busy", int'(bus_ready), 0);
            end
            m_cs = 1'b0;
            repeat (int'($urandom_range(4, 8))) tick();
        end

        // Reset asserted in the middle of a chunk.
        m_cs = 1'b1;
        wait_ready("t1_wait_ready");
        issue_chunk(9, 1'b1, 1'b1, 'h155, 'h0aa);
        spi_bits(3, 'h5, seen);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_bus_ready", int'(bus_ready), 1);
        chk("t1_comm_active", int'(comm_active), 0);
        chk("t1_pins", int'({s_cs, s_sclk, s_mosi, m_miso}), 0);
        chk("t1_real", int'({real_mosi_data, real_miso_data}), 0);
        m_cs = 1'b0; m_sclk = 1'b0; m_mosi = 1'b0; s_miso = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t1_ready_after_release", int'(bus_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
